// File: rtl/sprite_engine_multi_if.sv
// Pixel/bitmap bus of the multi-sprite compositor.
// Streaming with no valid/ready: the engine accepts one pixel every clock and returns its result two clocks later.
interface sprite_engine_multi_if #(
    parameter int COORD_W = 16
);
    logic [COORD_W-1:0] i_x;
    logic [COORD_W-1:0] i_y;
    logic               i_v_sync;
    logic [3:0]         i_btn;
    logic               i_auto;
    logic               i_bm_we;
    logic [7:0]         i_bm_addr;
    logic [1:0]         i_bm_data;
    logic [7:0]         o_red;
    logic [7:0]         o_green;
    logic [7:0]         o_blue;
    logic               o_sprite_hit;
    logic [2:0]         o_sprite_id;

    modport master (
        output i_x, i_y, i_v_sync, i_btn, i_auto, i_bm_we, i_bm_addr, i_bm_data,
        input  o_red, o_green, o_blue, o_sprite_hit, o_sprite_id
    );

    modport slave (
        input  i_x, i_y, i_v_sync, i_btn, i_auto, i_bm_we, i_bm_addr, i_bm_data,
        output o_red, o_green, o_blue, o_sprite_hit, o_sprite_id
    );
endinterface

// File: rtl/sprite_engine_multi.sv
// N_SPR sprites sharing one writable 16x16 2-bit bitmap, priority-composited
// onto the video stream with a fixed two-cycle latency.
module sprite_engine_multi #(
    parameter int N_SPR      = 4,
    parameter int SCALE_LOG2 = 2,
    parameter int SCREEN_W   = 800,
    parameter int SCREEN_H   = 600,
    parameter int COORD_W    = 16,
    parameter int SPEED      = 1
) (
    input logic i_clk,
    input logic i_rst,
    sprite_engine_multi_if.slave bus
);
    localparam int SIZE  = 16 << SCALE_LOG2;
    localparam int MAX_X = SCREEN_W - SIZE;
    localparam int MAX_Y = SCREEN_H - SIZE;
    localparam logic [COORD_W-1:0] MAX_XC  = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] MAX_YC  = COORD_W'(MAX_Y);
    localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);
    localparam logic [COORD_W:0]   SPEED_E = (COORD_W+1)'(SPEED);
    localparam logic [COORD_W:0]   SIZE_E  = (COORD_W+1)'(SIZE);

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               dir;   // 1 = increasing
        logic               flip;
    } axis_t;

    function automatic logic [COORD_W-1:0] reset_pos(input int k, input int pitch, input int lim);
        return (k * pitch > lim) ? COORD_W'(lim) : COORD_W'(k * pitch);
    endfunction

    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] lim);
        return (({1'b0, p} + SPEED_E) >= {1'b0, lim}) ? lim : p + SPEED_C;
    endfunction

    function automatic logic [COORD_W-1:0] sat_dec(input logic [COORD_W-1:0] p);
        return (p <= SPEED_C) ? '0 : p - SPEED_C;
    endfunction

    function automatic axis_t bounce(input axis_t a, input logic [COORD_W-1:0] lim);
        axis_t r;
        r = a;
        if (a.dir) begin
            r.pos = sat_inc(a.pos, lim);
            if (({1'b0, a.pos} + SPEED_E) >= {1'b0, lim}) begin
                r.dir  = 1'b0;
                r.flip = ~a.flip;
            end
        end else begin
            r.pos = sat_dec(a.pos);
            if (a.pos <= SPEED_C) begin
                r.dir  = 1'b1;
                r.flip = ~a.flip;
            end
        end
        return r;
    endfunction

    logic [COORD_W-1:0] pos_x [N_SPR];
    logic [COORD_W-1:0] pos_y [N_SPR];
    logic [N_SPR-1:0]   dir_x, dir_y, flip_x, flip_y;
    logic               v_sync_q;
    logic               tick;

    assign tick = bus.i_v_sync & ~v_sync_q;

    // Sprite 0 keeps its directions forced to + while manual so that enabling
    // i_auto starts the bounce from the current position heading +,+.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_sync_q <= 1'b1;
            dir_x    <= '1;
            dir_y    <= '1;
            flip_x   <= '0;
            flip_y   <= '0;
            for (int k = 0; k < N_SPR; k++) begin
                pos_x[k] <= reset_pos(k, 80, MAX_X);
                pos_y[k] <= reset_pos(k, 60, MAX_Y);
            end
        end else begin
            v_sync_q <= bus.i_v_sync;
            for (int k = 0; k < N_SPR; k++) begin
                if (k == 0 && !bus.i_auto) begin
                    dir_x[k] <= 1'b1;
                    dir_y[k] <= 1'b1;
                    if (tick) begin
                        if (bus.i_btn[0]) begin
                            pos_x[k]  <= sat_inc(pos_x[k], MAX_XC);
                            flip_x[k] <= 1'b0;
                        end else if (bus.i_btn[1]) begin
                            pos_x[k]  <= sat_dec(pos_x[k]);
                            flip_x[k] <= 1'b1;
                        end else if (bus.i_btn[2]) begin
                            pos_y[k]  <= sat_inc(pos_y[k], MAX_YC);
                            flip_y[k] <= 1'b0;
                        end else if (bus.i_btn[3]) begin
                            pos_y[k]  <= sat_dec(pos_y[k]);
                            flip_y[k] <= 1'b1;
                        end
                    end
                end else if (tick) begin
                    {pos_x[k], dir_x[k], flip_x[k]} <= bounce({pos_x[k], dir_x[k], flip_x[k]}, MAX_XC);
                    {pos_y[k], dir_y[k], flip_y[k]} <= bounce({pos_y[k], dir_y[k], flip_y[k]}, MAX_YC);
                end
            end
        end
    end

    logic [N_SPR-1:0] hit_c;
    logic [7:0]       addr_c [N_SPR];

    for (genvar k = 0; k < N_SPR; k++) begin : g_spr
        logic [COORD_W:0]   ex, ey, px, py;
        logic [COORD_W-1:0] off_x, off_y;
        logic [3:0]         col, row;
        assign ex    = {1'b0, bus.i_x};
        assign ey    = {1'b0, bus.i_y};
        assign px    = {1'b0, pos_x[k]};
        assign py    = {1'b0, pos_y[k]};
        assign hit_c[k] = (ex >= px) && (ex < px + SIZE_E) && (ey >= py) && (ey < py + SIZE_E);
        assign off_x = bus.i_x - pos_x[k];
        assign off_y = bus.i_y - pos_y[k];
        // Inverting a 4-bit index is the 15-n mirror.
        assign col   = 4'(off_x >> SCALE_LOG2) ^ {4{flip_x[k]}};
        assign row   = 4'(off_y >> SCALE_LOG2) ^ {4{flip_y[k]}};
        assign addr_c[k] = {row, col};
    end

    // Stored XOR 1 so that all-zero power-up content reads back as index 1.
    logic [1:0] bitmap [256];

    always_ff @(posedge i_clk) begin
        if (bus.i_bm_we) bitmap[bus.i_bm_addr] <= bus.i_bm_data ^ 2'b01;
    end

    // The bitmap is read on the stage-1 edge, so a write is read-first for the
    // pixel presented alongside it and visible from the next pixel on.
    logic [N_SPR-1:0] hit_q;
    logic [1:0]       idx_q [N_SPR];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hit_q <= '0;
            for (int k = 0; k < N_SPR; k++) idx_q[k] <= 2'd0;
        end else begin
            hit_q <= hit_c;
            for (int k = 0; k < N_SPR; k++) idx_q[k] <= bitmap[addr_c[k]] ^ 2'b01;
        end
    end

    logic       win_hit;
    logic [2:0] win_id;
    logic [1:0] win_idx;
    logic [23:0] rgb;

    always_comb begin
        win_hit = 1'b0;
        win_id  = 3'd0;
        win_idx = 2'd0;
        for (int k = N_SPR - 1; k >= 0; k--) begin
            if (hit_q[k] && idx_q[k] != 2'd0) begin
                win_hit = 1'b1;
                win_id  = 3'(k);
                win_idx = idx_q[k];
            end
        end
        case (win_idx)
            2'd1:    rgb = 24'hFF0000;
            2'd2:    rgb = 24'hFFFFFF;
            2'd3:    rgb = 24'h2121FF;
            default: rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_sprite_hit <= 1'b0;
            bus.o_sprite_id  <= 3'd0;
            bus.o_red        <= 8'd0;
            bus.o_green      <= 8'd0;
            bus.o_blue       <= 8'd0;
        end else begin
            bus.o_sprite_hit <= win_hit;
            bus.o_sprite_id  <= win_id;
            {bus.o_red, bus.o_green, bus.o_blue} <= rgb;
        end
    end
endmodule

// File: tb/tb_sprite_engine_multi.sv
// Bench for sprite_engine_multi: a reference model of sprite motion and compositing
// feeds an expected queue that is drained as the two-cycle pipeline delivers pixels.
module tb_sprite_engine_multi;
    localparam int N     = 4;
    localparam int SIZE  = 64;
    localparam int MAX_X = 736;
    localparam int MAX_Y = 536;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_engine_multi_if #(.COORD_W(16)) bus ();

    sprite_engine_multi #(
        .N_SPR(N), .SCALE_LOG2(2), .SCREEN_W(800), .SCREEN_H(600), .COORD_W(16), .SPEED(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    // {x[15:0], y[15:0], hit, id[2:0], rgb[23:0]}
    logic [59:0] exp_q[$];

    int         sx [N];
    int         sy [N];
    bit         dxp [N];
    bit         dyp [N];
    bit         fx [N];
    bit         fy [N];
    logic [1:0] bm [256];
    bit         vs_q_m;

    logic       cur_vs, cur_auto, cur_we;
    logic [3:0] cur_btn;
    logic [7:0] cur_addr;
    logic [1:0] cur_data;

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got hit=%0b id=%0d rgb=%06h, expected hit=%0b id=%0d rgb=%06h",
                     tag, got[27], got[26:24], got[23:0], exp[27], exp[26:24], exp[23:0]);
        end
    endtask

    function automatic logic [27:0] got_out();
        return {bus.o_sprite_hit, bus.o_sprite_id, bus.o_red, bus.o_green, bus.o_blue};
    endfunction

    function automatic logic [27:0] model_pixel(input logic [15:0] x, input logic [15:0] y);
        int xi, yi, col, row;
        logic [1:0] idx;
        xi = int'(x);
        yi = int'(y);
        for (int k = 0; k < N; k++) begin
            if (xi >= sx[k] && xi < sx[k] + SIZE && yi >= sy[k] && yi < sy[k] + SIZE) begin
                col = (xi - sx[k]) / 4;
                row = (yi - sy[k]) / 4;
                if (fx[k]) col = 15 - col;
                if (fy[k]) row = 15 - row;
                idx = bm[row * 16 + col];
                case (idx)
                    2'd1: return {1'b1, 3'(k), 24'hFF0000};
                    2'd2: return {1'b1, 3'(k), 24'hFFFFFF};
                    2'd3: return {1'b1, 3'(k), 24'h2121FF};
                    default: ;
                endcase
            end
        end
        return 28'h0;
    endfunction

    task automatic model_bounce(inout int p, inout bit d, inout bit f, input int lim);
        if (d) begin
            if (p + 1 >= lim) begin p = lim; d = 1'b0; f = !f; end
            else p = p + 1;
        end else begin
            if (p <= 1) begin p = 0; d = 1'b1; f = !f; end
            else p = p - 1;
        end
    endtask

    task automatic model_tick();
        for (int k = 0; k < N; k++) begin
            if (k == 0 && !cur_auto) begin
                if (cur_btn[0]) begin sx[0] = (sx[0] + 1 >= MAX_X) ? MAX_X : sx[0] + 1; fx[0] = 1'b0; end
                else if (cur_btn[1]) begin sx[0] = (sx[0] <= 1) ? 0 : sx[0] - 1; fx[0] = 1'b1; end
                else if (cur_btn[2]) begin sy[0] = (sy[0] + 1 >= MAX_Y) ? MAX_Y : sy[0] + 1; fy[0] = 1'b0; end
                else if (cur_btn[3]) begin sy[0] = (sy[0] <= 1) ? 0 : sy[0] - 1; fy[0] = 1'b1; end
            end else begin
                model_bounce(sx[k], dxp[k], fx[k], MAX_X);
                model_bounce(sy[k], dyp[k], fy[k], MAX_Y);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            sx[k]  = (k * 80 > MAX_X) ? MAX_X : k * 80;
            sy[k]  = (k * 60 > MAX_Y) ? MAX_Y : k * 60;
            dxp[k] = 1'b1;
            dyp[k] = 1'b1;
            fx[k]  = 1'b0;
            fy[k]  = 1'b0;
        end
        vs_q_m = 1'b1;
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y);
        bus.i_x       = x;
        bus.i_y       = y;
        bus.i_v_sync  = cur_vs;
        bus.i_btn     = cur_btn;
        bus.i_auto    = cur_auto;
        bus.i_bm_we   = cur_we;
        bus.i_bm_addr = cur_addr;
        bus.i_bm_data = cur_data;
    endtask

    // One pixel per clock; the model advances exactly as the DUT does on this edge.
    task automatic step(input logic [15:0] x, input logic [15:0] y);
        logic [59:0] e;
        drive(x, y);
        exp_q.push_back({x, y, model_pixel(x, y)});
        if (cur_vs && !vs_q_m) model_tick();
        vs_q_m = cur_vs;
        if (!cur_auto) begin dxp[0] = 1'b1; dyp[0] = 1'b1; end
        if (cur_we) bm[cur_addr] = cur_data;
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check($sformatf("pix(%0d,%0d)", e[59:44], e[43:28]), got_out(), e[27:0]);
        end
    endtask

    task automatic apply_reset(input logic [15:0] x, input logic [15:0] y);
        rst    = 1'b1;
        cur_we = 1'b0;
        drive(x, y);
        @(posedge clk);
        #1;
        check("reset_out", got_out(), 28'h0);
        @(posedge clk);
        #1;
        check("reset_hold", got_out(), 28'h0);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        exp_q.push_back({x, y, 28'h0});
    endtask

    task automatic probe_rand();
        int k, x, y;
        k = $urandom_range(0, N - 1);
        x = sx[k] + int'($urandom_range(0, 71)) - 4;
        y = sy[k] + int'($urandom_range(0, 71)) - 4;
        step(16'(x), 16'(y));
    endtask

    task automatic probe_overlaps();
        int lo_x, hi_x, lo_y, hi_y;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                lo_x = (sx[i] > sx[j]) ? sx[i] : sx[j];
                hi_x = ((sx[i] < sx[j]) ? sx[i] : sx[j]) + SIZE;
                lo_y = (sy[i] > sy[j]) ? sy[i] : sy[j];
                hi_y = ((sy[i] < sy[j]) ? sy[i] : sy[j]) + SIZE;
                if (lo_x < hi_x && lo_y < hi_y) begin
                    repeat (2) step(16'(lo_x + int'($urandom_range(0, hi_x - lo_x - 1))),
                                    16'(lo_y + int'($urandom_range(0, hi_y - lo_y - 1))));
                end
            end
        end
    endtask

    task automatic edge_probes();
        int x0, y0;
        for (int k = 0; k < N; k++) begin
            x0 = sx[k];
            y0 = sy[k];
            step(16'(x0), 16'(y0));
            step(16'(x0 - 1), 16'(y0));
            step(16'(x0 + 63), 16'(y0 + 63));
            step(16'(x0 + 64), 16'(y0 + 63));
            step(16'(x0 + 63), 16'(y0 + 64));
        end
    endtask

    task automatic frames(input int n, input bit with_overlaps);
        repeat (n) begin
            cur_vs = 1'b1;
            probe_rand();
            cur_vs = 1'b0;
            probe_rand();
            if (with_overlaps) probe_overlaps();
        end
    endtask

    initial begin
        rst      = 1'b1;
        cur_vs   = 1'b1;
        cur_btn  = 4'b0000;
        cur_auto = 1'b0;
        cur_we   = 1'b0;
        cur_addr = 8'd0;
        cur_data = 2'd0;
        for (int a = 0; a < 256; a++) bm[a] = 2'd1;
        model_reset();
        drive(16'd0, 16'd0);

        // power-up bitmap, v_sync held high across reset release
        apply_reset(16'd0, 16'd0);
        step(16'd0, 16'd0);
        step(16'd64, 16'd0);
        step(16'd63, 16'd63);
        step(16'd0, 16'd64);
        step(16'd80, 16'd60);
        step(16'd79, 16'd59);
        cur_vs = 1'b0;
        edge_probes();

        // read-first bitmap write of sprite 0's corner cell
        cur_we   = 1'b1;
        cur_addr = 8'h00;
        cur_data = 2'd0;
        step(16'd0, 16'd0);
        cur_we = 1'b0;
        step(16'd0, 16'd0);
        step(16'd3, 16'd3);
        step(16'd4, 16'd0);

        for (int a = 0; a < 256; a++) begin
            cur_we   = 1'b1;
            cur_addr = 8'(a);
            cur_data = 2'($urandom_range(0, 3));
            probe_rand();
        end
        cur_we = 1'b0;
        edge_probes();

        // manual sprite 0: saturate right, then priority and each direction
        cur_btn = 4'b0001;
        frames(800, 1'b0);
        edge_probes();
        cur_btn = 4'b0011;
        frames(5, 1'b0);
        edge_probes();
        cur_btn = 4'b0010;
        frames(3, 1'b0);
        cur_btn = 4'b0100;
        frames(3, 1'b0);
        cur_btn = 4'b1000;
        frames(3, 1'b0);
        cur_btn = 4'b0000;
        frames(3, 1'b0);
        edge_probes();

        // all sprites bouncing, probing wherever footprints overlap
        cur_auto = 1'b1;
        frames(1500, 1'b1);
        edge_probes();

        // mid-line reset while a sprite is being hit
        step(16'(sx[1] + 5), 16'(sy[1] + 5));
        apply_reset(16'(sx[2] + 3), 16'(sy[2] + 3));
        cur_auto = 1'b0;
        cur_vs   = 1'b0;
        edge_probes();
        cur_auto = 1'b1;
        frames(20, 1'b1);
        edge_probes();

        step(16'd0, 16'd0);
        step(16'd0, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
